// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and memory signals of the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      if_req_valid;
  logic [ADDR_WIDTH-1:0]     if_req_addr;
  logic                      if_req_ready;
  logic                      if_resp_valid;
  logic [DATA_WIDTH-1:0]     if_resp_data;

  logic                      dm_req_valid;
  logic                      dm_req_we;
  logic [ADDR_WIDTH-1:0]     dm_req_addr;
  logic [DATA_WIDTH-1:0]     dm_req_wdata;
  logic [DATA_WIDTH/8-1:0]   dm_req_wstrb;
  logic                      dm_req_ready;
  logic                      dm_resp_valid;
  logic [DATA_WIDTH-1:0]     dm_resp_data;

  logic                      mem_en;
  logic                      mem_we;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH/8-1:0]   mem_wstrb;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_resp_valid, if_resp_data,
    input  dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_req_wstrb,
    output dm_req_ready, dm_resp_valid, dm_resp_data,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_resp_valid, if_resp_data,
    output dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_req_wstrb,
    input  dm_req_ready, dm_resp_valid, dm_resp_data,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and load/store requesters
module mem_port_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_LATENCY   = 2,
  parameter int PRIORITY_DATA = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic                  last_grant;
  logic                  cur_grant;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0] if_data_q;
  logic [DATA_WIDTH-1:0] dm_data_q;
  logic                  grant_if;
  logic                  grant_dm;

  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state == IDLE) begin
      if (bus.if_req_valid && bus.dm_req_valid) begin
        if (PRIORITY_DATA != 0 || last_grant == GRANT_IF) begin
          grant_dm = 1'b1;
        end else begin
          grant_if = 1'b1;
        end
      end else begin
        grant_if = bus.if_req_valid;
        grant_dm = bus.dm_req_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      last_grant <= GRANT_DM;
      cur_grant  <= GRANT_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      if_data_q  <= '0;
      dm_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // a grant only exists while its requester is valid, so grant == handshake
          if (grant_if || grant_dm) begin
            cur_grant  <= grant_dm;
            last_grant <= grant_dm;
            addr_q     <= grant_dm ? bus.dm_req_addr : bus.if_req_addr;
            we_q       <= grant_dm & bus.dm_req_we;
            wdata_q    <= grant_dm ? bus.dm_req_wdata : '0;
            wstrb_q    <= grant_dm ? bus.dm_req_wstrb : '1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_q) begin
            dm_data_q <= '0;
            state     <= RESP;
          end else begin
            wait_cnt <= 4'(MEM_LATENCY - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            if (cur_grant == GRANT_DM) begin
              dm_data_q <= bus.mem_rdata;
            end else begin
              if_data_q <= bus.mem_rdata;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.if_req_ready  = grant_if;
  assign bus.dm_req_ready  = grant_dm;
  assign bus.if_resp_valid = (state == RESP) && (cur_grant == GRANT_IF);
  assign bus.dm_resp_valid = (state == RESP) && (cur_grant == GRANT_DM);
  assign bus.if_resp_data  = if_data_q;
  assign bus.dm_resp_data  = dm_data_q;

  assign bus.mem_en    = (state == ACCESS);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter over four parameter sets
module tb_mem_port_arbiter;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  logic [N-1:0] if_v, dm_v, dm_we;
  logic [N-1:0] if_rdy, dm_rdy, if_rv, dm_rv, m_en, m_we, bsy;
  logic [31:0]  if_a [N];
  logic [31:0]  dm_a [N];
  logic [31:0]  dm_wd [N];
  logic [3:0]   dm_ws [N];
  logic [31:0]  if_rd [N];
  logic [31:0]  dm_rd [N];
  logic [31:0]  m_addr [N];
  logic [31:0]  m_wdata [N];
  logic [3:0]   m_wstrb [N];

  typedef struct {
    int          inst;
    int          side;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic int lat_of(input int g);
    return (g == 2) ? 1 : (g == 3) ? 15 : 2;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance 0: LAT 2 round-robin, 1: LAT 2 data priority, 2: LAT 1, 3: LAT 15
  for (genvar g = 0; g < N; g++) begin : inst
    localparam int LAT = (g == 2) ? 1 : (g == 3) ? 15 : 2;
    localparam int PRI = (g == 1) ? 1 : 0;
    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    int          en_cyc = -100;
    logic [31:0] en_addr = '0;

    assign bus.if_req_valid = if_v[g];
    assign bus.if_req_addr  = if_a[g];
    assign bus.dm_req_valid = dm_v[g];
    assign bus.dm_req_we    = dm_we[g];
    assign bus.dm_req_addr  = dm_a[g];
    assign bus.dm_req_wdata = dm_wd[g];
    assign bus.dm_req_wstrb = dm_ws[g];
    assign if_rdy[g]  = bus.if_req_ready;
    assign dm_rdy[g]  = bus.dm_req_ready;
    assign if_rv[g]   = bus.if_resp_valid;
    assign dm_rv[g]   = bus.dm_resp_valid;
    assign if_rd[g]   = bus.if_resp_data;
    assign dm_rd[g]   = bus.dm_resp_data;
    assign m_en[g]    = bus.mem_en;
    assign m_we[g]    = bus.mem_we;
    assign m_addr[g]  = bus.mem_addr;
    assign m_wdata[g] = bus.mem_wdata;
    assign m_wstrb[g] = bus.mem_wstrb;

    // read data is only correct in the cycle exactly LAT after mem_en; junk otherwise
    assign bus.mem_rdata = (cyc == en_cyc + LAT) ? mem_fn(en_addr) : (32'hBAD0_0000 | 32'(cyc));
    always @(posedge clk) begin
      if (bus.mem_en) begin
        en_cyc  <= cyc;
        en_addr <= bus.mem_addr;
      end
    end

    mem_port_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT), .PRIORITY_DATA(PRI)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .busy(bsy[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int g, input int side, input logic [31:0] data, input int c);
    exp_t e;
    e.inst = g;
    e.side = side;
    e.data = data;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input int g);
    check("rst_mem_en", 32'(m_en[g]), 32'd0);
    check("rst_mem_we", 32'(m_we[g]), 32'd0);
    check("rst_mem_addr", m_addr[g], 32'd0);
    check("rst_mem_wdata", m_wdata[g], 32'd0);
    check("rst_mem_wstrb", 32'(m_wstrb[g]), 32'd0);
    check("rst_busy", 32'(bsy[g]), 32'd0);
    check("rst_ready", 32'({if_rdy[g], dm_rdy[g]}), 32'd0);
    check("rst_resp_valid", 32'({if_rv[g], dm_rv[g]}), 32'd0);
    check("rst_if_data", if_rd[g], 32'd0);
    check("rst_dm_data", dm_rd[g], 32'd0);
  endtask

  // call at a falling edge with the DUT idle; returns in the ACCESS cycle, 1 unit after the edge
  task automatic issue(input int g, input int side, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] ws, input bit push);
    int c;
    if (side == 0) begin
      if_v[g] = 1'b1;
      if_a[g] = addr;
    end else begin
      dm_v[g]  = 1'b1;
      dm_we[g] = we;
      dm_a[g]  = addr;
      dm_wd[g] = wd;
      dm_ws[g] = ws;
    end
    #1;
    c = cyc;
    check("req_ready", 32'(side == 0 ? if_rdy[g] : dm_rdy[g]), 32'd1);
    if (push) push_exp(g, side, we ? 32'd0 : mem_fn(addr), c + 2 + (we ? 0 : lat_of(g)));
    @(negedge clk);
    if_v[g] = 1'b0;
    dm_v[g] = 1'b0;
    #1;
    check("access_mem_en", 32'(m_en[g]), 32'd1);
    check("access_mem_addr", m_addr[g], addr);
    check("access_mem_we", 32'(m_we[g]), 32'(we));
    check("access_mem_wdata", m_wdata[g], we ? wd : 32'd0);
    check("access_mem_wstrb", 32'(m_wstrb[g]), 32'(side == 1 ? ws : 4'hF));
    check("access_busy", 32'(bsy[g]), 32'd1);
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      #1;
      if (!bsy[g]) break;
      n++;
    end
    if (n >= 40) check("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  // both requesters held valid; call at the falling edge of the expected accept cycle
  task automatic tie_grant(input int g, input int side);
    #1;
    check("tie_if_ready", 32'(if_rdy[g]), 32'(side == 0));
    check("tie_dm_ready", 32'(dm_rdy[g]), 32'(side == 1));
    push_exp(g, side, mem_fn(side == 1 ? dm_a[g] : if_a[g]), cyc + 2 + lat_of(g));
    @(negedge clk);
    if (side == 1) dm_a[g] += 32'd4;
    else if_a[g] += 32'd4;
    repeat (lat_of(g) + 2) @(negedge clk);
  endtask

  always begin
    @(negedge clk);
    #2;
    for (int g = 0; g < N; g++) begin
      if (if_rdy[g] || dm_rdy[g]) check("ready_exclusive", 32'(if_rdy[g] & dm_rdy[g]), 32'd0);
      for (int s = 0; s < 2; s++) begin
        logic        rv;
        logic [31:0] rd;
        exp_t        e;
        rv = (s == 1) ? dm_rv[g] : if_rv[g];
        rd = (s == 1) ? dm_rd[g] : if_rd[g];
        if (rv) begin
          if (exp_q.size() == 0) begin
            check("resp_unexpected", 32'(g * 2 + s + 1), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("resp_inst", 32'(g), 32'(e.inst));
            check("resp_side", 32'(s), 32'(e.side));
            check("resp_data", rd, e.data);
            check("resp_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int g = 0; g < N; g++) begin
      if_v[g] = 1'b0; dm_v[g] = 1'b0; dm_we[g] = 1'b0;
      if_a[g] = '0; dm_a[g] = '0; dm_wd[g] = '0; dm_ws[g] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int g = 0; g < N; g++) check_zero(g);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // round-robin ties, first tie to fetch
    if_a[0] = 32'h1000; dm_a[0] = 32'h2000; dm_we[0] = 1'b0;
    if_v[0] = 1'b1; dm_v[0] = 1'b1;
    tie_grant(0, 0);
    tie_grant(0, 1);
    tie_grant(0, 0);
    tie_grant(0, 1);
    if_v[0] = 1'b0; dm_v[0] = 1'b0;
    wait_idle(0);

    // single fetch with busy profile
    issue(0, 0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      #1;
      check("fetch_busy", 32'(bsy[0]), 32'd1);
    end
    @(negedge clk);
    #1;
    check("fetch_idle_after_resp", 32'(bsy[0]), 32'd0);
    @(negedge clk);

    // stores: partial strobe, then zero strobe
    issue(0, 1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'h3, 1'b1);
    @(negedge clk);
    #1;
    check("store_no_second_en", 32'(m_en[0]), 32'd0);
    wait_idle(0);
    issue(0, 1, 1'b1, 32'h204, 32'h1234_5678, 4'h0, 1'b1);
    wait_idle(0);

    // data priority: DM wins every tie until it drops
    if_a[1] = 32'h3000; dm_a[1] = 32'h4000; dm_we[1] = 1'b0;
    if_v[1] = 1'b1; dm_v[1] = 1'b1;
    tie_grant(1, 1);
    tie_grant(1, 1);
    tie_grant(1, 1);
    dm_v[1] = 1'b0;
    tie_grant(1, 0);
    if_v[1] = 1'b0;
    wait_idle(1);

    // latency extremes
    issue(2, 0, 1'b0, 32'h140, 32'h0, 4'h0, 1'b1);
    wait_idle(2);
    issue(3, 1, 1'b0, 32'h180, 32'h0, 4'hF, 1'b1);
    wait_idle(3);

    // reset during WAIT aborts the fetch silently
    issue(0, 0, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero(0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(0, 0, 1'b0, 32'h400, 32'h0, 4'h0, 1'b1);
    wait_idle(0);
    // fresh reset state means the first tie goes to fetch again
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if_a[0] = 32'h500; dm_a[0] = 32'h600; dm_we[0] = 1'b0;
    if_v[0] = 1'b1; dm_v[0] = 1'b1;
    tie_grant(0, 0);
    if_v[0] = 1'b0; dm_v[0] = 1'b0;
    wait_idle(0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
